sqrt_sched: RTL and testbench
=============================

Name: sqrt_sched

Overview:
Round-robin scheduler that shares one integer square-root engine (8-bit operand `a`, `start`/`valid` handshake, 8-bit `sqrt` result) between NREQ requesters. It arbitrates requests, latches the winner's operand and drives the engine start pulse. It then waits for the engine's valid, with a watchdog, and returns the result and a done pulse to the granted requester. It sits between the request sources (button/switch front ends) and the shared sqrt engine/display path.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width
TIMEOUT, 64, max WAIT cycles before error (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester request level
operand  in  NREQ*WIDTH  flattened operands; requester i at [i*WIDTH +: WIDTH]
ack  out  NREQ  one-hot 1-cycle pulse: request i accepted
done  out  NREQ  one-hot 1-cycle pulse: result for i available
result  out  WIDTH  last result, held until next done
err  out  1  1-cycle pulse coincident with done on timeout
busy  out  1  high whenever state != IDLE
eng_a  out  WIDTH  operand to engine
eng_start  out  1  1-cycle start pulse to engine
eng_valid  in  1  engine result valid
eng_sqrt  in  WIDTH  engine result

Behaviour:
- All outputs registered. On reset low: state=IDLE, ack=0, done=0, err=0, busy=0, eng_start=0, eng_a=0, result=0, rr pointer=0, timer=0.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If |req, pick the first asserted index at or after the pointer, wrapping modulo NREQ.
  - Latch idx and operand[idx] into eng_a; set pointer=(idx+1) mod NREQ; go to LAUNCH.
  - If no req, stay in IDLE.
- LAUNCH (1 cycle): ack[idx]=1, eng_start=1; timer cleared; go to WAIT.
- WAIT:
  - timer increments each cycle.
  - eng_valid is ignored while timer==0, so stale valid held from a previous job is rejected.
  - If eng_valid=1 and timer>=1: result<=eng_sqrt, go to RESP.
  - Else if timer==TIMEOUT-1: result<=0, set err flag, go to RESP.
- RESP (1 cycle): done[idx]=1, err=flag; flag cleared; go to IDLE.
- Latency: req sampled at edge k (IDLE), so ack and eng_start appear in cycle k+1. Valid sampled at edge m gives done in cycle m+1. Minimum idle-to-done is 4 cycles.
- eng_a is held stable from LAUNCH through RESP.
- Requesters:
  - Hold req and operand until ack; operand is sampled only in IDLE.
  - Dropping req before grant withdraws the request; no ack is issued.
  - req held after ack is treated as a new request at the next IDLE.
- Simultaneous requests are served strictly in rotation; no requester waits more than NREQ-1 jobs.
- Operand changes during WAIT have no effect.
- Reset mid-operation aborts the job: no done, no err, pointer returns to 0. The engine's own reset is driven externally.
- Widths: timer is clog2(TIMEOUT) bits; idx and pointer are clog2(NREQ) bits, minimum 1.

Decomposition:
- Shared package/header sqrt_pkg holds:
  - state encodings (IDLE=0, LAUNCH=1, WAIT=2, RESP=3);
  - default WIDTH=8;
  - a clog2 function.
- One sub-module, rr_arbiter (params NREQ):
  - inputs: req, pointer;
  - outputs: grant_valid, grant_idx;
  - purely combinational rotate / priority-encode / rotate back.
- sqrt_sched contains the FSM, timer, pointer and data registers.

Test Plan:
- Single request, engine model with 3-cycle latency: req[0]=1, operand0=49 → ack[0] one cycle after sampling; done[0] pulse with result=7, err=0; busy low afterward.
- Simultaneous requests: req[0] (100) and req[1] (4) both held, pointer=0 → serves 0 first (result 10, done[0]), then 1 (result 2, done[1]); pointer ends at 2.
- Fairness: all four req held with operands 4, 9, 16, 25 → ack order 0,1,2,3,0; results 2,3,4,5.
- Timeout: TIMEOUT=8, engine never asserts valid → done[idx] and err pulse together in RESP; result=0; next request is then served normally.
- Stale valid: engine holds eng_valid=1 from the prior job and drops it 1 cycle after start → not captured in the first WAIT cycle; new result captured when valid re-asserts.
- Reset mid-WAIT: reset low for 2 cycles during WAIT → all outputs 0, no done; after release, a pending req[2] is granted first with pointer=0 scan.

Source files
------------

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: definitions shared by the square-root scheduler.
//   state_e   - scheduler FSM state encoding
//   DEF_WIDTH - default operand/result width
//   clog2     - ceiling log2, usable in parameter expressions
//   idx_width - clog2 with a floor of 1, for index/pointer registers
package sqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/sqrt_sched_if.sv
// sqrt_sched_if: requester-side and engine-side signals of the scheduler.
//   req/operand        - request levels and flattened operands (to scheduler)
//   ack/done           - one-hot accept / completion pulses (from scheduler)
//   result/err/busy    - returned result, timeout flag, activity status
//   eng_a/eng_start    - operand and start pulse towards the sqrt engine
//   eng_valid/eng_sqrt - engine completion and result
// Modports: slave = the scheduler, master = requesters plus engine.
interface sqrt_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = sqrt_pkg::DEF_WIDTH
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] operand;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic                  err;
  logic                  busy;
  logic [WIDTH-1:0]      eng_a;
  logic                  eng_start;
  logic                  eng_valid;
  logic [WIDTH-1:0]      eng_sqrt;

  modport slave (
    input  req, operand, eng_valid, eng_sqrt,
    output ack, done, result, err, busy, eng_a, eng_start
  );

  modport master (
    output req, operand, eng_valid, eng_sqrt,
    input  ack, done, result, err, busy, eng_a, eng_start
  );

endinterface

// File: rtl/sqrt_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req         - request vector
//   pointer     - index with highest priority this round
//   grant_valid - any request present
//   grant_idx   - first asserted index at or after pointer, wrapping
// The request vector is rotated so the pointer lands on bit 0, the lowest
// set bit is found, and the pointer is added back modulo NREQ.
module rr_arbiter
  import sqrt_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_idx
);

  logic [NREQ-1:0] rot;
  logic [IW-1:0]   enc;

  // rot[gi] = req[(gi + pointer) mod NREQ]
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic sel_bit;
    always_comb begin
      sel_bit = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
        if (((gi + int'(pointer)) % NREQ) == j) sel_bit = req[j];
      end
    end
    assign rot[gi] = sel_bit;
  end

  always_comb begin
    enc = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = IW'(i);
    end
  end

  always_comb begin
    int sum;
    sum = int'(enc) + int'(pointer);
    if (sum >= NREQ) sum = sum - NREQ;
    grant_idx   = IW'(sum);
    grant_valid = |req;
  end

endmodule

// File: rtl/sqrt_sched.sv
// sqrt_sched: shares one square-root engine between NREQ requesters.
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - sqrt_sched_if.slave: requester handshake and engine handshake
// Flow: IDLE picks a requester round-robin and latches its operand, LAUNCH
// pulses ack and eng_start, WAIT waits for eng_valid under a watchdog,
// RESP pulses done (with err on timeout). All outputs come from flops.
module sqrt_sched
  import sqrt_pkg::*;
#(
  parameter int  NREQ    = 4,
  parameter int  WIDTH   = DEF_WIDTH,
  parameter int  TIMEOUT = 64,
  localparam int IW      = idx_width(NREQ),
  localparam int TW      = clog2(TIMEOUT)
) (
  input logic        clk,
  input logic        reset,
  sqrt_sched_if.slave bus
);

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [WIDTH-1:0]  eng_a_q, eng_a_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              err_flag_q, err_flag_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              eng_start_q, eng_start_d;

  logic              grant_valid;
  logic [IW-1:0]     grant_idx;
  logic [WIDTH-1:0]  op_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_op
    assign op_arr[gi] = bus.operand[gi*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req         (bus.req),
    .pointer     (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    eng_a_d     = eng_a_q;
    result_d    = result_q;
    err_flag_d  = err_flag_q;
    ack_d       = '0;
    done_d      = '0;
    err_d       = 1'b0;
    eng_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          idx_d       = grant_idx;
          eng_a_d     = op_arr[grant_idx];
          ptr_d       = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IW'(1);
          ack_d       = ONE_HOT0 << grant_idx;
          eng_start_d = 1'b1;
          state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        // A valid seen on the first WAIT cycle may still be the previous
        // job's result held by the engine, so it is not accepted.
        if (bus.eng_valid && (timer_q != '0)) begin
          result_d   = bus.eng_sqrt;
          err_flag_d = 1'b0;
          state_d    = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          result_d   = '0;
          err_flag_d = 1'b1;
          state_d    = ST_RESP;
        end
        // done/err are registered, so they are set on the way into RESP.
        if (state_d == ST_RESP) begin
          done_d = ONE_HOT0 << idx_q;
          err_d  = err_flag_d;
        end
      end
      ST_RESP: begin
        err_flag_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ptr_q       <= '0;
      timer_q     <= '0;
      eng_a_q     <= '0;
      result_q    <= '0;
      err_flag_q  <= 1'b0;
      ack_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      eng_a_q     <= eng_a_d;
      result_q    <= result_d;
      err_flag_q  <= err_flag_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      eng_start_q <= eng_start_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.eng_a     = eng_a_q;
  assign bus.eng_start = eng_start_q;

endmodule

// File: tb/tb_sqrt_sched.sv
// tb_sqrt_sched: directed bench for sqrt_sched (NREQ=4, WIDTH=8, TIMEOUT=8)
// with a behavioural sqrt engine of 3-cycle latency that can run normally,
// never answer, or keep its valid asserted between jobs.
module tb_sqrt_sched;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 8;
  localparam int LAT     = 3;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_NEVER  = 1;
  localparam int MODE_STICKY = 2;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;
  int   eng_mode;

  sqrt_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  sqrt_sched #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] isqrt(input logic [7:0] a);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= int'(a)) r++;
    return 8'(r);
  endfunction

  // Engine model: updates 1 time unit after each rising edge.
  initial begin
    logic [7:0] job_a;
    int         age;
    bit         busy_e;
    job_a         = '0;
    age           = 0;
    busy_e        = 1'b0;
    bus.eng_valid = 1'b0;
    bus.eng_sqrt  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.eng_start) begin
        job_a  = bus.eng_a;
        age    = 0;
        busy_e = 1'b1;
      end else if (busy_e) begin
        age++;
      end
      if (busy_e && age == LAT && eng_mode != MODE_NEVER) begin
        bus.eng_valid = 1'b1;
        bus.eng_sqrt  = isqrt(job_a);
        busy_e        = 1'b0;
      end else if (eng_mode == MODE_STICKY) begin
        // stale valid survives the start cycle and the one after it
        if (busy_e && age >= 2) bus.eng_valid = 1'b0;
      end else begin
        bus.eng_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] v);
    bus.operand[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ack"},       32'(bus.ack),       0);
    chk({tag, "_done"},      32'(bus.done),      0);
    chk({tag, "_err"},       32'(bus.err),       0);
    chk({tag, "_busy"},      32'(bus.busy),      0);
    chk({tag, "_eng_start"}, 32'(bus.eng_start), 0);
    chk({tag, "_eng_a"},     32'(bus.eng_a),     0);
    chk({tag, "_result"},    32'(bus.result),    0);
  endtask

  // Waits for an ack, checks the grant, then drops the requests in
  // drop_mask and optionally corrupts the granted operand.
  task automatic wait_ack(input int exp_idx, input logic [7:0] exp_op,
                          input logic [3:0] drop_mask, input bit scramble,
                          output bit ok);
    int cyc;
    int stray;
    cyc   = 0;
    stray = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.done != '0) stray++;
    end while (bus.ack == '0 && cyc < 100);
    chk("ack_seen", 32'(bus.ack != '0), 1);
    chk("no_done_before_ack", 32'(stray), 0);
    ok = (bus.ack != '0);
    if (ok) begin
      chk("ack_onehot", 32'(bus.ack), 32'(4'b0001 << exp_idx));
      chk("eng_start",  32'(bus.eng_start), 1);
      chk("eng_a",      32'(bus.eng_a), 32'(exp_op));
      chk("busy_launch", 32'(bus.busy), 1);
      bus.req = bus.req & ~drop_mask;
      if (scramble) set_op(exp_idx, 8'hFF);
    end
  endtask

  task automatic run_job(input int exp_idx, input logic [7:0] exp_op,
                         input logic [7:0] exp_res, input bit exp_err,
                         input int exp_lat, input logic [3:0] drop_mask,
                         input bit scramble);
    bit ok;
    int lat;
    wait_ack(exp_idx, exp_op, drop_mask, scramble, ok);
    if (!ok) return;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.done == '0 && lat < 100);
    chk("done_seen",   32'(bus.done != '0), 1);
    chk("done_onehot", 32'(bus.done), 32'(4'b0001 << exp_idx));
    chk("result",      32'(bus.result), 32'(exp_res));
    chk("err",         32'(bus.err), 32'(exp_err));
    chk("latency",     32'(lat), 32'(exp_lat));
    chk("eng_a_held",  32'(bus.eng_a), 32'(exp_op));
    $display("job idx=%0d op=%0d result=%0d err=%0d latency=%0d",
             exp_idx, exp_op, bus.result, bus.err, lat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    n_vec       = 0;
    n_miss      = 0;
    eng_mode    = MODE_NORMAL;
    reset       = 1'b0;
    bus.req     = '0;
    bus.operand = '0;

    // power-on reset state
    repeat (2) @(negedge clk);
    check_outputs_zero("por");
    reset = 1'b1;
    @(negedge clk);

    // single request; operand changed after ack must not matter
    set_op(0, 8'd49);
    bus.req[0] = 1'b1;
    run_job(0, 8'd49, 8'd7, 1'b0, 4, 4'b0001, 1'b1);
    @(negedge clk);
    chk("busy_after", 32'(bus.busy), 0);
    chk("done_after", 32'(bus.done), 0);

    // two simultaneous requests from pointer 0, then pointer-at-2 probe
    do_reset();
    set_op(0, 8'd100);
    set_op(1, 8'd4);
    bus.req = 4'b0011;
    run_job(0, 8'd100, 8'd10, 1'b0, 4, 4'b0001, 1'b0);
    run_job(1, 8'd4,   8'd2,  1'b0, 4, 4'b0010, 1'b0);
    set_op(0, 8'd64);
    set_op(2, 8'd144);
    bus.req = 4'b0101;
    run_job(2, 8'd144, 8'd12, 1'b0, 4, 4'b0100, 1'b0);
    run_job(0, 8'd64,  8'd8,  1'b0, 4, 4'b0001, 1'b0);

    // fairness with all four held
    do_reset();
    set_op(0, 8'd4);
    set_op(1, 8'd9);
    set_op(2, 8'd16);
    set_op(3, 8'd25);
    bus.req = 4'b1111;
    run_job(0, 8'd4,  8'd2, 1'b0, 4, 4'b0000, 1'b0);
    run_job(1, 8'd9,  8'd3, 1'b0, 4, 4'b0000, 1'b0);
    run_job(2, 8'd16, 8'd4, 1'b0, 4, 4'b0000, 1'b0);
    run_job(3, 8'd25, 8'd5, 1'b0, 4, 4'b0000, 1'b0);
    run_job(0, 8'd4,  8'd2, 1'b0, 4, 4'b1111, 1'b0);

    // watchdog timeout, then a normal job
    eng_mode = MODE_NEVER;
    set_op(1, 8'd50);
    bus.req[1] = 1'b1;
    run_job(1, 8'd50, 8'd0, 1'b1, TIMEOUT + 1, 4'b0010, 1'b0);
    eng_mode = MODE_NORMAL;
    set_op(2, 8'd225);
    bus.req[2] = 1'b1;
    run_job(2, 8'd225, 8'd15, 1'b0, 4, 4'b0100, 1'b0);

    // stale valid held across the next start
    eng_mode = MODE_STICKY;
    set_op(3, 8'd121);
    bus.req[3] = 1'b1;
    run_job(3, 8'd121, 8'd11, 1'b0, 4, 4'b1000, 1'b0);
    set_op(0, 8'd16);
    bus.req[0] = 1'b1;
    run_job(0, 8'd16, 8'd4, 1'b0, 4, 4'b0001, 1'b0);
    eng_mode = MODE_NORMAL;

    // reset in the middle of WAIT; pointer must restart at 0
    do_reset();
    set_op(2, 8'd81);
    set_op(3, 8'd36);
    bus.req[2] = 1'b1;
    wait_ack(2, 8'd81, 4'b0000, 1'b0, ok);
    bus.req[3] = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("mid_wait_reset");
    reset = 1'b1;
    run_job(2, 8'd81, 8'd9, 1'b0, 4, 4'b0100, 1'b0);
    run_job(3, 8'd36, 8'd6, 1'b0, 4, 4'b1000, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
